// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the RV32I core: steps each instruction through its
// state schedule, drives datapath muxes and strobes, and handshakes with the shared memory port.
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       ill_q, ill_d;
    logic       bus_q, bus_d;
    logic       mem_state;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        ill_d   = ill_q;
        bus_d   = bus_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d = S_TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            S_AUIPC:    state_d = S_ALUWB;
            default:    state_d = S_TRAP;
        endcase

        // A ready arriving on the limit cycle wins; otherwise the wait is fatal.
        if (mem_state && !mem_ready) begin
            if (wait_q + 8'd1 == WAIT_LIMIT) begin
                state_d = S_TRAP;
                bus_d   = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ill_q   <= ill_d;
            bus_q   <= bus_d;
        end
    end

    // Strobes depend on mem_ready in the same cycle, so they are decoded from state here.
    always_comb begin
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        ImmSrc        = 3'b000;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        state_o       = 4'd0;
        if (!reset) begin
            illegal_instr = ill_q;
            bus_error     = bus_q;
            state_o       = state_q;
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        ALUSrcB   = 2'b10;
                        ResultSrc = 2'b10;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB:  RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    PCWrite = branch_taken;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_JALR1: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_JALR2: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_LUI: begin
                    ImmSrc    = 3'b100;
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                end
                S_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b100;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm: a per-instruction schedule model
// builds the expected control vector for every cycle, then the DUT is driven and compared.
module tb_mc_control_fsm;

    localparam int MAX = 15;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                           OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct packed {
        logic       mem_req, adr_src, ir_write, pc_write, mem_write, reg_write;
        logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
        logic [2:0] imm_src;
        logic       illegal, bus_err;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic       ready;
        logic [6:0] op;
        logic       bt;
        ctrl_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       illegal_instr, bus_error;
    logic [3:0] state_o;
    ctrl_t      act;

    step_t      q[$];
    bit         m_ill, m_bus;
    logic [6:0] cur_op;
    logic       cur_bt;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] legal_ops [9] = '{LOAD, STORE, OPR, OPI, BR, JAL, JALR, LUI, AUIPC};

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o)
    );

    assign act = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr, bus_error};

    task automatic push(input logic rdy, input ctrl_t c);
        step_t s;
        c.illegal = m_ill;
        c.bus_err = m_bus;
        s.rst = 1'b0; s.ready = rdy; s.op = cur_op; s.bt = cur_bt; s.exp = c;
        q.push_back(s);
    endtask

    // mem_ready in a cycle with no request must be ignored, so it is randomized there.
    task automatic push_idle(input ctrl_t c);
        push(1'($urandom_range(0, 1)), c);
    endtask

    task automatic push_reset(input int n);
        step_t s;
        m_ill = 1'b0;
        m_bus = 1'b0;
        repeat (n) begin
            s.rst = 1'b1; s.ready = 1'($urandom_range(0, 1)); s.op = 7'($urandom);
            s.bt = 1'($urandom_range(0, 1)); s.exp = '0;
            q.push_back(s);
        end
    endtask

    task automatic push_trap(input int n);
        ctrl_t c;
        c = '0;
        repeat (n) push_idle(c);
    endtask

    // Memory phase: lat wait cycles then a ready cycle; a wait of MAX cycles is fatal.
    task automatic push_mem(input int lat, input ctrl_t wait_c, input ctrl_t done_c,
                            output bit trapped);
        trapped = 1'b0;
        if (lat >= MAX) begin
            repeat (MAX) push(1'b0, wait_c);
            m_bus   = 1'b1;
            trapped = 1'b1;
        end else begin
            repeat (lat) push(1'b0, wait_c);
            push(1'b1, done_c);
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input logic bt, input int lf, input int lm,
                             output bit trapped);
        ctrl_t w, d, c, wb;
        cur_op = op;
        cur_bt = bt;
        w = '0; w.mem_req = 1'b1;
        d = w; d.ir_write = 1'b1; d.pc_write = 1'b1; d.alu_src_b = 2'b10; d.result_src = 2'b10;
        push_mem(lf, w, d, trapped);
        if (trapped) return;
        c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
        c.imm_src = (op == JAL) ? 3'b011 : 3'b010;
        push_idle(c);
        wb = '0; wb.reg_write = 1'b1;
        c = '0;
        case (op)
            LOAD, STORE: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.imm_src = (op == STORE) ? 3'b001 : 3'b000;
                push_idle(c);
                w = '0; w.mem_req = 1'b1; w.adr_src = 1'b1; w.mem_write = (op == STORE);
                push_mem(lm, w, w, trapped);
                if (trapped) return;
                if (op == LOAD) begin
                    c = '0; c.result_src = 2'b01; c.reg_write = 1'b1;
                    push_idle(c);
                end
            end
            OPR, OPI: begin
                c.alu_src_a = 2'b10; c.alu_op = 2'b10;
                c.alu_src_b = (op == OPI) ? 2'b01 : 2'b00;
                push_idle(c);
                push_idle(wb);
            end
            BR: begin
                c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_write = bt;
                push_idle(c);
            end
            JAL: begin
                c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
                push_idle(c);
                push_idle(wb);
            end
            JALR: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                push_idle(c);
                c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
                push_idle(c);
                push_idle(wb);
            end
            LUI: begin
                c.imm_src = 3'b100; c.result_src = 2'b11; c.reg_write = 1'b1;
                push_idle(c);
            end
            AUIPC: begin
                c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 3'b100;
                push_idle(c);
                push_idle(wb);
            end
            default: begin
                m_ill   = 1'b1;
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic run(input string name);
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            reset        = q[i].rst;
            mem_ready    = q[i].ready;
            opcode       = q[i].op;
            branch_taken = q[i].bt;
            @(negedge clk);
            n_cmp++;
            if (act !== q[i].exp) begin
                n_bad++;
                $display("FAIL %s step %0d: ctrl got %h expected %h", name, i, act, q[i].exp);
            end
            if (q[i].rst) begin
                n_cmp++;
                if (state_o !== 4'd0) begin
                    n_bad++;
                    $display("FAIL %s step %0d: state_o in reset got %h expected 0", name, i, state_o);
                end
            end
        end
        q.delete();
    endtask

    task automatic test_reset();
        bit tr;
        push_reset(3);
        add_instr(LUI, 1'b0, 2, 0, tr);
        run("reset");
    endtask

    task automatic test_addi();
        bit tr;
        add_instr(OPI, 1'b0, 0, 0, tr);
        run("addi");
    endtask

    task automatic test_load_store();
        bit tr;
        add_instr(LOAD, 1'b0, 1, 3, tr);
        add_instr(STORE, 1'b1, 0, 2, tr);
        add_instr(OPR, 1'b0, 0, 0, tr);
        run("load_store");
    endtask

    task automatic test_branch_jump();
        bit tr;
        add_instr(BR, 1'b0, 0, 0, tr);
        add_instr(BR, 1'b1, 0, 0, tr);
        add_instr(JALR, 1'b0, 0, 0, tr);
        add_instr(JAL, 1'b1, 1, 0, tr);
        add_instr(AUIPC, 1'b0, 0, 0, tr);
        run("branch_jump");
    endtask

    task automatic test_illegal();
        bit tr;
        add_instr(7'b0000000, 1'b0, 0, 0, tr);
        push_trap(6);
        push_reset(1);
        add_instr(1'b1 ? 7'b1111111 : 7'b0, 1'b0, 1, 0, tr);
        push_trap(3);
        push_reset(1);
        add_instr(OPI, 1'b0, 0, 0, tr);
        run("illegal");
    endtask

    task automatic test_timeout();
        bit tr;
        add_instr(OPI, 1'b0, MAX + 5, 0, tr);
        push_trap(4);
        push_reset(1);
        add_instr(LOAD, 1'b0, 0, MAX, tr);
        push_trap(3);
        push_reset(1);
        add_instr(LUI, 1'b0, 0, 0, tr);
        run("timeout");
    endtask

    task automatic test_ready_at_limit();
        bit tr;
        add_instr(LOAD, 1'b0, MAX - 1, MAX - 1, tr);
        add_instr(STORE, 1'b0, 10, MAX - 1, tr);
        run("ready_at_limit");
    endtask

    task automatic test_reset_mid_wait();
        bit tr;
        ctrl_t w;
        cur_op = LOAD;
        w = '0; w.mem_req = 1'b1;
        repeat (10) push(1'b0, w);
        push_reset(1);
        add_instr(OPI, 1'b0, MAX - 1, 0, tr);
        run("reset_mid_wait");
    endtask

    task automatic test_random();
        bit tr;
        int lf, lm;
        for (int i = 0; i < 60; i++) begin
            lf = ($urandom_range(0, 9) == 0) ? MAX - 1 : int'($urandom_range(0, 3));
            lm = ($urandom_range(0, 9) == 0) ? MAX - 1 : int'($urandom_range(0, 3));
            add_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), lf, lm, tr);
        end
        run("random");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
